// File: rtl/hw_pwm_pkg.sv
// Shared definitions for the PWM generator and its companion detector benches.
package hw_pwm_pkg;

   // Default interval counter width, shared so generator and detector agree.
   localparam int unsigned PWM_COUNT_WIDTH = 32;

   // Generator state encoding.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HIGH = 2'd1;
   localparam logic [1:0] ST_LOW  = 2'd2;

endpackage

// File: rtl/hw_pwm_shadow.sv
// Double buffer for the PWM interval counts: software writes land in the
// shadow pair, and the active pair is only updated when the generator
// signals a safe point (period start / boundary).
module hw_pwm_shadow
   import hw_pwm_pkg::*;
#(
   parameter int unsigned COUNT_WIDTH = PWM_COUNT_WIDTH
)(
   input  logic                   i_clock,
   input  logic                   i_reset_n,
   input  logic                   i_load,
   input  logic                   i_apply,
   input  logic [COUNT_WIDTH-1:0] i_high_count,
   input  logic [COUNT_WIDTH-1:0] i_low_count,
   output logic [COUNT_WIDTH-1:0] o_active_high,
   output logic [COUNT_WIDTH-1:0] o_active_low,
   output logic                   o_pending
);

   logic [COUNT_WIDTH-1:0] r_shadow_high;
   logic [COUNT_WIDTH-1:0] r_shadow_low;
   logic [COUNT_WIDTH-1:0] r_active_high;
   logic [COUNT_WIDTH-1:0] r_active_low;
   logic                   r_pending;

   // Apply copies the pre-load shadow; a same-cycle load stays pending.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_shadow_high <= '0;
         r_shadow_low  <= '0;
         r_active_high <= '0;
         r_active_low  <= '0;
         r_pending     <= 1'b0;
      end else begin
         if (i_apply) begin
            r_active_high <= r_shadow_high;
            r_active_low  <= r_shadow_low;
         end
         if (i_load) begin
            r_shadow_high <= i_high_count;
            r_shadow_low  <= i_low_count;
         end
         if (i_load) begin
            r_pending <= 1'b1;
         end else if (i_apply) begin
            r_pending <= 1'b0;
         end
      end
   end

   assign o_active_high = r_active_high;
   assign o_active_low  = r_active_low;
   assign o_pending     = r_pending;

endmodule

// File: rtl/hw_pwm_gen.sv
// Hardware PWM generator. A programmed interval N lasts N+1 clocks so the
// pulse-width detector reads back exactly the programmed values. New counts
// are double-buffered and only take effect at a period boundary.
module hw_pwm_gen
   import hw_pwm_pkg::*;
#(
   parameter int unsigned CLK_FREQUENCY_HZ = 100000000,
   parameter int unsigned COUNT_WIDTH      = PWM_COUNT_WIDTH
)(
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic                   load,
   input  logic [COUNT_WIDTH-1:0] high_count_in,
   input  logic [COUNT_WIDTH-1:0] low_count_in,
   output logic                   pwm,
   output logic                   period_start,
   output logic                   pending
);

   // Elaboration-time sanity check; the clock frequency is informational only.
   if (CLK_FREQUENCY_HZ == 0 || COUNT_WIDTH == 0) begin : g_param_check
      $error("hw_pwm_gen: CLK_FREQUENCY_HZ and COUNT_WIDTH must be nonzero");
   end

   logic [1:0]             r_state;
   logic [COUNT_WIDTH-1:0] r_counter;
   logic                   r_pwm;
   logic                   r_period_start;

   logic [1:0]             w_next_state;
   logic [COUNT_WIDTH-1:0] w_next_counter;
   logic                   w_start;
   logic                   w_boundary;
   logic                   w_apply;
   logic [COUNT_WIDTH-1:0] w_active_high;
   logic [COUNT_WIDTH-1:0] w_active_low;
   logic                   w_pending;

   hw_pwm_shadow #(
      .COUNT_WIDTH (COUNT_WIDTH)
   ) u_shadow (
      .i_clock       (clock),
      .i_reset_n     (reset_n),
      .i_load        (load),
      .i_apply       (w_apply),
      .i_high_count  (high_count_in),
      .i_low_count   (low_count_in),
      .o_active_high (w_active_high),
      .o_active_low  (w_active_low),
      .o_pending     (w_pending)
   );

   // Leaving IDLE always takes the shadow; a running boundary only if pending.
   assign w_apply = w_start | (w_boundary & w_pending);

   // Next-state and counter logic; equality compares, counter clears on match.
   always_comb begin
      w_next_state   = r_state;
      w_next_counter = r_counter + COUNT_WIDTH'(1);
      w_start        = 1'b0;
      w_boundary     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_next_counter = '0;
            if (enable) begin
               w_next_state = ST_HIGH;
               w_start      = 1'b1;
            end
         end
         ST_HIGH: begin
            if (!enable) begin
               w_next_state   = ST_IDLE;
               w_next_counter = '0;
            end else if (r_counter == w_active_high) begin
               w_next_state   = ST_LOW;
               w_next_counter = '0;
            end
         end
         ST_LOW: begin
            if (!enable) begin
               w_next_state   = ST_IDLE;
               w_next_counter = '0;
            end else if (r_counter == w_active_low) begin
               w_next_state   = ST_HIGH;
               w_next_counter = '0;
               w_boundary     = 1'b1;
            end
         end
         default: begin
            w_next_state   = ST_IDLE;
            w_next_counter = '0;
         end
      endcase
   end

   // State, counter and registered outputs derived from the next state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= ST_IDLE;
         r_counter      <= '0;
         r_pwm          <= 1'b0;
         r_period_start <= 1'b0;
      end else begin
         r_state        <= w_next_state;
         r_counter      <= w_next_counter;
         r_pwm          <= (w_next_state == ST_HIGH);
         r_period_start <= w_start | w_boundary;
      end
   end

   assign pwm          = r_pwm;
   assign period_start = r_period_start;
   assign pending      = w_pending;

endmodule

// File: doc/hw_pwm_gen.md
Name: hw_pwm_gen

Overview:
Hardware PWM generator. It is the transmit-side counterpart of the pulse-width detector. Microblaze writes high/low interval counts through GPIO, and the block drives a PWM waveform whose interval lengths the detector reads back unchanged. New counts are double-buffered and take effect only at a period boundary, so there are no glitched or truncated periods.

Parameters:
CLK_FREQUENCY_HZ, 100000000, system clock frequency; documentation/timing reference only, no functional effect.
COUNT_WIDTH, 32, width of interval counters and count inputs.

Ports:
clock  input  1  100 MHz system clock
reset_n  input  1  asynchronous, active-low reset
enable  input  1  level; 1 = generate PWM, 0 = hold output low
load  input  1  single-cycle strobe; captures high_count_in/low_count_in into the shadow registers
high_count_in  input  COUNT_WIDTH  requested high interval; high phase lasts high_count_in+1 clocks
low_count_in  input  COUNT_WIDTH  requested low interval; low phase lasts low_count_in+1 clocks
pwm  output  1  PWM waveform, registered
period_start  output  1  one-cycle pulse coincident with the first high cycle of every period
pending  output  1  shadow holds values not yet applied

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, pwm=0, period_start=0, pending=0, counter=0, shadow and active registers=0. Outputs are valid immediately on reset assertion. Release is synchronous to clock.
- Encoding: a programmed value N gives N+1 clocks. This matches the detector, which reports (cycles-1), so a loopback reads back exactly the programmed values. Value 0 gives 1 clock, so pwm toggles every cycle when both values are 0. There is no 0%/100% duty mode; enable=0 is the constant-low case.
- load: on any cycle with load=1, shadow <= inputs and pending <= 1. load is accepted in every state, including IDLE.
- States: IDLE, HIGH, LOW. pwm=1 only in HIGH.
- IDLE: if enable=1, then next cycle state=HIGH, active <= shadow, pending <= 0 (unless load=1 that same cycle, in which case pending stays 1), counter <= 0, period_start=1. Latency from enable rising to pwm=1 is 1 clock.
- HIGH: counter increments each cycle. When counter==active_high, next state=LOW and counter <= 0.
- LOW: counter increments each cycle. When counter==active_low, the period boundary occurs:
  - Next state=HIGH, counter <= 0, period_start=1 for that first high cycle.
  - If pending=1, active <= shadow and pending <= 0.
- Simultaneous load and boundary: the boundary applies the shadow contents from before this cycle's load. The new load is written to shadow, pending stays 1, and it is applied at the following boundary. There is no bypass path.
- enable=0 in HIGH or LOW: next cycle state=IDLE, pwm=0, counter <= 0. The current period is abandoned, not completed. Shadow and pending are retained.
- Counter width is COUNT_WIDTH. Compares are equality only. A maximum value (all ones) gives 2^COUNT_WIDTH clocks with no overflow issue, because the counter resets on match.
- Multiple loads within one period: the last one wins.
- Reset mid-period: pwm drops immediately (asynchronous) and all state is cleared as above.

Decomposition:
- Shared package hw_pwm_pkg: state encoding constants (IDLE/HIGH/LOW) and the default COUNT_WIDTH, so the detector and generator benches share widths.
- One natural sub-module, hw_pwm_shadow: the shadow/active register pair plus the pending flag. Inputs: load, apply, data. Outputs: active values and pending.
- The FSM and counter stay in the top module.

Test Plan:
- Load high=3, low=5, then enable=1 -> pwm high 4 clocks, low 6 clocks, period 10. period_start pulses every 10 clocks. A hw_detect loopback reads high_count=3, low_count=5.
- Running at 3/5, load 1/1 mid-high-phase -> pending=1. Current period completes as 4/6. The next period is 2 high / 2 low, and pending clears at that boundary.
- Load 7/7 on the exact boundary cycle (last LOW clock) -> the boundary applies the previous shadow. The 7/7 setting takes effect one period later, with pending=1 in between.
- high=0, low=0 -> pwm toggles every clock and period_start pulses every 2 clocks.
- enable=0 during HIGH of a 3/5 setting -> pwm=0 the next clock, state IDLE. Re-enable -> a full 4-clock high phase starts 1 clock later.
- reset_n=0 mid-LOW -> pwm, pending and period_start are 0 immediately, with no clock edge needed. After release with enable=1 and shadow=0, the waveform is 1/1 cycles.
